// File: rtl/gsim_residual_check.sv
// Residual checker for the 16x16 banded GSIM system: snoops b and x, streams r = (b<<16) - A*x.
// Build option GSIM_RES_SAT_EN: saturate r_data to 32-bit signed instead of wrapping.
module gsim_residual_check #(
    parameter logic [31:0] TOL    = 32'h0000_0100,
    parameter int          N_ROWS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_en,
    input  logic [15:0] b_in,
    input  logic        out_valid,
    input  logic [31:0] x_out,
    output logic        r_valid,
    input  logic        r_ready,
    output logic [3:0]  r_idx,
    output logic [31:0] r_data,
    output logic        done,
    output logic [31:0] max_abs,
    output logic        converged
);

    typedef enum logic [2:0] {IDLE, LOAD_B, WAIT_X, LOAD_X, CALC, FIN} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_cnt;
    logic [4:0]         r_row;
    logic [15:0]        r_b [N_ROWS];
    logic [31:0]        r_x [N_ROWS];
    logic [39:0]        r_max_acc;

    logic signed [39:0] w_xc, w_s1, w_s2, w_s3;
    logic signed [39:0] w_a, w_b_ext, w_res;
    logic [39:0]        w_abs;
    logic [31:0]        w_r_word;
    logic [31:0]        w_max_sat;
    logic               w_advance;
    logic               w_last;
    int                 w_d;

    assign w_advance = !r_valid || r_ready;
    assign w_last    = r_valid && r_ready && (r_idx == 4'd15);

    // Gather the band taps around the current row; out-of-range neighbours stay zero.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_xc = '0;
        w_s1 = '0;
        w_s2 = '0;
        w_s3 = '0;
        w_d  = 0;
        for (int k = 0; k < N_ROWS; k++) begin
            w_d = k - int'(r_row[3:0]);
            if (w_d == 0)
                w_xc = {{8{r_x[k][31]}}, r_x[k]};
            if (w_d == 1 || w_d == -1)
                w_s1 = w_s1 + {{8{r_x[k][31]}}, r_x[k]};
            if (w_d == 2 || w_d == -2)
                w_s2 = w_s2 + {{8{r_x[k][31]}}, r_x[k]};
            if (w_d == 3 || w_d == -3)
                w_s3 = w_s3 + {{8{r_x[k][31]}}, r_x[k]};
        end
    end

    always_comb begin
        w_a     = (w_xc <<< 4) + (w_xc <<< 2)
                - ((w_s1 <<< 3) + (w_s1 <<< 2) + w_s1)
                + ((w_s2 <<< 2) + (w_s2 <<< 1))
                - w_s3;
        w_b_ext = {{8{r_b[r_row[3:0]][15]}}, r_b[r_row[3:0]], 16'h0000};
        w_res   = w_b_ext - w_a;
        w_abs   = w_res[39] ? 40'(-w_res) : 40'(w_res);
`ifdef GSIM_RES_SAT_EN
        if (!w_res[39] && (w_res[38:31] != 8'h00))
            w_r_word = 32'h7FFF_FFFF;
        else if (w_res[39] && (w_res[38:31] != 8'hFF))
            w_r_word = 32'h8000_0000;
        else
            w_r_word = w_res[31:0];
`else
        w_r_word = w_res[31:0];
`endif
        w_max_sat = (r_max_acc[39:32] != 8'h00) ? 32'hFFFF_FFFF : r_max_acc[31:0];
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_en) w_next = LOAD_B;
            LOAD_B:  if (in_en && r_cnt == 4'd15) w_next = WAIT_X;
            WAIT_X:  if (out_valid) w_next = LOAD_X;
            LOAD_X:  if (out_valid && r_cnt == 4'd15) w_next = CALC;
            CALC:    if (w_last) w_next = FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the register files are cleared on reset so an aborted vector leaves no stale operands.
            for (int k = 0; k < N_ROWS; k++) begin
                r_b[k] <= '0;
                r_x[k] <= '0;
            end
            r_cnt     <= '0;
            r_row     <= '0;
            r_max_acc <= '0;
            r_valid   <= 1'b0;
            r_idx     <= '0;
            r_data    <= '0;
            done      <= 1'b0;
            max_abs   <= '0;
            converged <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_en) begin
                    r_b[0] <= b_in;
                    r_cnt  <= 4'd1;
                end
                LOAD_B: if (in_en) begin
                    r_b[r_cnt] <= b_in;
                    r_cnt      <= r_cnt + 4'd1;
                end
                WAIT_X: if (out_valid) begin
                    r_x[0] <= x_out;
                    r_cnt  <= 4'd1;
                end
                LOAD_X: if (out_valid) begin
                    r_x[r_cnt] <= x_out;
                    r_cnt      <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_row     <= '0;
                        r_max_acc <= '0;
                    end
                end
                CALC: if (w_advance) begin
                    if (w_last) begin
                        r_valid   <= 1'b0;
                        done      <= 1'b1;
                        max_abs   <= w_max_sat;
                        converged <= (w_max_sat <= TOL);
                    end else if (!r_row[4]) begin
                        r_valid <= 1'b1;
                        r_idx   <= r_row[3:0];
                        r_data  <= w_r_word;
                        r_row   <= r_row + 5'd1;
                        if (w_abs > r_max_acc)
                            r_max_acc <= w_abs;
                    end
                end
                FIN: done <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
